nexus_nonce_ctrl: RTL

- Parametrised nonce dispatcher and result checker around the SK1024 hash pipeline (FirstSkeinRound -> SecondSkeinRound -> NexusKeccak1024).
- Issues one nonce per cycle over a programmable, possibly wrapping range, and tracks in-flight valid slots with a PIPE_DEPTH shift register.
- Compares each returned hash qword against a programmable target and queues hits (nonce and qword) in a small ready/valid result FIFO for the miner interface.
- Replaces the fixed 32-zero-bit check and the "current nonce minus latency" reconstruction with exact per-result nonce tracking.

---
 rtl/nexus_pkg.sv | 17 +
 rtl/nexus_result_fifo.sv | 49 ++++
 rtl/nexus_nonce_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/nexus_pkg.sv
// Shared constants and FSM encoding for the SK1024 nonce dispatcher.
// Pipeline depth is derived from the per-block stage counts of the hash cores.
package nexus_pkg;

    localparam int SKEINBLKSTAGES   = 50;
    localparam int KECCAKBLKSTAGES  = 96;
    // Two Skein rounds, three Keccak blocks, plus input and output registers.
    localparam int NEXUS_PIPE_DEPTH = 2*SKEINBLKSTAGES + 3*KECCAKBLKSTAGES + 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } nonce_state_e;

endpackage

// File: rtl/nexus_result_fifo.sv
// Small synchronous result FIFO; head is combinational from storage, 0 when empty.
// Push while full is accepted only if a pop happens in the same cycle.
module nexus_result_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty,
    output logic             push_ok
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             pop_en;
    logic             push_en;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_en  = pop && !empty;
    assign push_en = push && (!full || pop_en);
    assign push_ok = push_en;

    // Gating keeps the outputs at zero after reset without clearing storage.
    assign head_dat = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/nexus_nonce_ctrl.sv
// Issues one nonce per cycle into the SK1024 pipe and queues hash hits with exact nonces.
// pipe_* registered (1 cycle); results PIPE_DEPTH cycles later; hits dropped (overflow) when FIFO full.
module nexus_nonce_ctrl
    import nexus_pkg::*;
#(
    parameter int PIPE_DEPTH = NEXUS_PIPE_DEPTH,
    parameter int NONCE_W    = 64,
    parameter int TARGET_W   = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 32
) (
    input  logic                clk,
    input  logic                nHashRst,
    input  logic                start,
    input  logic                abort,
    input  logic [NONCE_W-1:0]  start_nonce,
    input  logic [NONCE_W-1:0]  end_nonce,
    input  logic [TARGET_W-1:0] target,
    output logic [NONCE_W-1:0]  pipe_nonce,
    output logic                pipe_valid,
    input  logic [TARGET_W-1:0] hash_qword,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [NONCE_W-1:0]  res_nonce,
    output logic [TARGET_W-1:0] res_hash,
    output logic                busy,
    output logic                done,
    output logic                overflow,
    output logic [CNT_W-1:0]    hit_count
);

    localparam int CW = $clog2(PIPE_DEPTH + 1);
    localparam int FW = NONCE_W + TARGET_W;

    nonce_state_e         state;
    logic [NONCE_W-1:0]   issue_nonce;
    logic [NONCE_W-1:0]   end_r;
    logic [NONCE_W-1:0]   out_nonce;
    logic [TARGET_W-1:0]  tgt_r;
    logic [PIPE_DEPTH-1:0] valid_sr;
    logic [CW-1:0]        inflight;

    logic                 start_acc;
    logic                 issue;
    logic                 qual;
    logic                 hit;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 push_ok;
    logic [FW-1:0]        head_dat;

    assign start_acc = (state == ST_IDLE) && start;
    assign issue     = (state == ST_RUN) && !abort;
    assign qual      = valid_sr[PIPE_DEPTH-1];
    assign hit       = qual && (hash_qword <= tgt_r);
    assign pop       = res_valid && res_ready;
    assign res_valid = !fifo_empty;
    assign res_nonce = head_dat[FW-1:TARGET_W];
    assign res_hash  = head_dat[TARGET_W-1:0];

    always_ff @(posedge clk or negedge nHashRst) begin
        if (!nHashRst) begin
            state       <= ST_IDLE;
            pipe_valid  <= 1'b0;
            pipe_nonce  <= '0;
            issue_nonce <= '0;
            end_r       <= '0;
            tgt_r       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    pipe_valid <= 1'b0;
                    done       <= 1'b0;
                    if (start) begin
                        issue_nonce <= start_nonce;
                        end_r       <= end_nonce;
                        tgt_r       <= target;
                        busy        <= 1'b1;
                        state       <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        pipe_valid <= 1'b0;
                        state      <= ST_DRAIN;
                    end else begin
                        pipe_valid  <= 1'b1;
                        pipe_nonce  <= issue_nonce;
                        issue_nonce <= issue_nonce + 1'b1;
                        if (issue_nonce == end_r) state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    pipe_valid <= 1'b0;
                    if (inflight == '0) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    pipe_valid <= 1'b0;
                    done       <= 1'b0;
                    busy       <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

    // Results leave the pipe in issue order, so a simple follower counter names each one.
    always_ff @(posedge clk or negedge nHashRst) begin
        if (!nHashRst) begin
            valid_sr  <= '0;
            inflight  <= '0;
            out_nonce <= '0;
            overflow  <= 1'b0;
            hit_count <= '0;
        end else begin
            valid_sr <= {valid_sr[PIPE_DEPTH-2:0], pipe_valid};

            case ({issue, qual})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase

            if (start_acc) begin
                out_nonce <= start_nonce;
                overflow  <= 1'b0;
                hit_count <= '0;
            end else begin
                if (qual) out_nonce <= out_nonce + 1'b1;
                if (hit && !push_ok) overflow <= 1'b1;
                if (hit && (hit_count != {CNT_W{1'b1}})) hit_count <= hit_count + 1'b1;
            end
        end
    end

    nexus_result_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_res_fifo (
        .clk      (clk),
        .rst_n    (nHashRst),
        .push     (hit),
        .push_dat ({out_nonce, hash_qword}),
        .pop      (pop),
        .head_dat (head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .push_ok  (push_ok)
    );

endmodule
